// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mem_arbiter : round-robin arbiter of two requesters onto one rd/wr master
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int DATA_LEN = 128,
    parameter int TIMEOUT  = 1023
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                c0_rd_req,
    input  logic                c0_wr_req,
    input  logic [26:0]         c0_addr,
    input  logic [DATA_LEN-1:0] c0_wr_data,
    output logic [DATA_LEN-1:0] c0_rd_data,
    output logic                c0_done,
    input  logic                c1_rd_req,
    input  logic                c1_wr_req,
    input  logic [26:0]         c1_addr,
    input  logic [DATA_LEN-1:0] c1_wr_data,
    output logic [DATA_LEN-1:0] c1_rd_data,
    output logic                c1_done,
    output logic                rd_en,
    output logic [26:0]         rd_addr,
    input  logic [DATA_LEN-1:0] rd_data,
    input  logic                rd_fin,
    output logic                wr_en,
    output logic [26:0]         wr_addr,
    output logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_fin,
    output logic                busy,
    output logic                grant,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] c_timeout_cnt = 16'(TIMEOUT);

    state_t                state_q,    state_d;
    logic                  grant_q,    grant_d;
    logic                  rd_en_q,    rd_en_d;
    logic                  wr_en_q,    wr_en_d;
    logic [26:0]           rd_addr_q,  rd_addr_d;
    logic [26:0]           wr_addr_q,  wr_addr_d;
    logic [DATA_LEN-1:0]   wr_data_q,  wr_data_d;
    logic [DATA_LEN-1:0]   rd_data0_q, rd_data0_d;
    logic [DATA_LEN-1:0]   rd_data1_q, rd_data1_d;
    logic                  done0_q,    done0_d;
    logic                  done1_q,    done1_d;
    logic [15:0]           cnt_q,      cnt_d;
    logic                  tout_q,     tout_d;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_win;
    logic                  w_win_wr;
    logic [26:0]           w_win_addr;
    logic [DATA_LEN-1:0]   w_win_wdata;

    assign w_req0      = c0_rd_req | c0_wr_req;
    assign w_req1      = c1_rd_req | c1_wr_req;
    // On contention the requester other than the last grant wins.
    assign w_win       = (w_req0 & w_req1) ? ~grant_q : w_req1;
    assign w_win_wr    = w_win ? c1_wr_req  : c0_wr_req;
    assign w_win_addr  = w_win ? c1_addr    : c0_addr;
    assign w_win_wdata = w_win ? c1_wr_data : c0_wr_data;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_data0_d = rd_data0_q;
        rd_data1_d = rd_data1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        cnt_d      = cnt_q;
        tout_d     = tout_q;

        case (state_q)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    grant_d = w_win;
                    cnt_d   = 16'd0;
                    if (w_win_wr) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = w_win_addr;
                        wr_data_d = w_win_wdata;
                        state_d   = WR_WAIT;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = w_win_addr;
                        state_d   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_fin) begin
                    if (grant_q) rd_data1_d = rd_data;
                    else         rd_data0_d = rd_data;
                    state_d = DONE;
                end else if (cnt_q == c_timeout_cnt) begin
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WR_WAIT: begin
                if (wr_fin) begin
                    state_d = DONE;
                end else if (cnt_q == c_timeout_cnt) begin
                    tout_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The done pulse is registered on the edge that enters DONE.
        if (state_d == DONE && state_q != DONE) begin
            done0_d = ~grant_q;
            done1_d = grant_q;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            grant_q    <= 1'b1;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data0_q <= '0;
            rd_data1_q <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            cnt_q      <= 16'd0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            cnt_q      <= cnt_d;
            tout_q     <= tout_d;
        end
    end

    assign c0_rd_data  = rd_data0_q;
    assign c1_rd_data  = rd_data1_q;
    assign c0_done     = done0_q;
    assign c1_done     = done1_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != IDLE);
    assign grant       = grant_q;
    assign timeout_err = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_arbiter : randomized transaction-level check of mem_arbiter
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int DW = 128;
    localparam int TO = 1023;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [1:0]        rd_req, wr_req, cdone;
    logic [26:0]       req_addr  [2];
    logic [DW-1:0]     req_wdata [2];
    logic [DW-1:0]     rdat_o    [2];
    logic              rd_en, wr_en, rd_fin, wr_fin, busy, grant, timeout_err;
    logic [26:0]       rd_addr, wr_addr;
    logic [DW-1:0]     mem_rdata, wr_data;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level reference state
    logic [1:0]        pend_rd, pend_wr;
    logic [26:0]       m_addr  [2];
    logic [DW-1:0]     m_wdata [2];
    logic [DW-1:0]     m_rdata [2];
    logic              m_grant;
    logic              m_tout;

    always #5 ACLK = ~ACLK;

    mem_arbiter #(.DATA_LEN(DW), .TIMEOUT(TO)) u_dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .c0_rd_req  (rd_req[0]),
        .c0_wr_req  (wr_req[0]),
        .c0_addr    (req_addr[0]),
        .c0_wr_data (req_wdata[0]),
        .c0_rd_data (rdat_o[0]),
        .c0_done    (cdone[0]),
        .c1_rd_req  (rd_req[1]),
        .c1_wr_req  (wr_req[1]),
        .c1_addr    (req_addr[1]),
        .c1_wr_data (req_wdata[1]),
        .c1_rd_data (rdat_o[1]),
        .c1_done    (cdone[1]),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (mem_rdata),
        .rd_fin     (rd_fin),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_fin     (wr_fin),
        .busy       (busy),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_reqs();
        rd_req       = pend_rd;
        wr_req       = pend_wr;
        req_addr[0]  = m_addr[0];
        req_addr[1]  = m_addr[1];
        req_wdata[0] = m_wdata[0];
        req_wdata[1] = m_wdata[1];
    endtask

    task automatic model_reset();
        pend_rd    = '0;
        pend_wr    = '0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_grant    = 1'b1;
        m_tout     = 1'b0;
        drive_reqs();
    endtask

    task automatic check_reset_vals();
        check_val("rst_rd_en",   rd_en, 0);
        check_val("rst_wr_en",   wr_en, 0);
        check_val("rst_rd_addr", rd_addr, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_rdata0",  rdat_o[0], 0);
        check_val("rst_rdata1",  rdat_o[1], 0);
        check_val("rst_done",    cdone, 0);
        check_val("rst_grant",   grant, 1);
        check_val("rst_busy",    busy, 0);
        check_val("rst_tout",    timeout_err, 0);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        rd_fin = 1'b0;
        wr_fin = 1'b0;
        mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge ACLK);
        #1;
        check_reset_vals();
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();
    endtask

    // Picks new requests for idle requesters; at least one requester pends.
    task automatic gen_reqs();
        for (int n = 0; n < 2; n++) begin
            if (!pend_rd[n] && !pend_wr[n] && ($urandom_range(3) != 0)) begin
                case ($urandom_range(2))
                    0:       pend_rd[n] = 1'b1;
                    1:       pend_wr[n] = 1'b1;
                    default: begin pend_rd[n] = 1'b1; pend_wr[n] = 1'b1; end
                endcase
                m_addr[n]  = 27'($urandom());
                m_wdata[n] = rand_data();
            end
        end
        if (pend_rd == 2'b00 && pend_wr == 2'b00) begin
            pend_rd[0] = 1'b1;
            m_addr[0]  = 27'($urandom());
        end
    endtask

    // One complete transaction from grant edge to return to IDLE.
    task automatic run_round(input int delay, input bit no_fin, input bit inject,
                             input bit drop_early, input logic [DW-1:0] rdv);
        int   w;
        int   n;
        logic is_wr;
        logic a0, a1;
        a0 = pend_rd[0] | pend_wr[0];
        a1 = pend_rd[1] | pend_wr[1];
        if (a0 && a1) w = m_grant ? 0 : 1;
        else          w = a1 ? 1 : 0;
        is_wr = pend_wr[w];
        drive_reqs();
        tick();
        m_grant = w[0];
        check_val("grant_busy", busy, 1);
        check_val("grant", grant, w);
        check_val("wr_en_strobe", wr_en, is_wr);
        check_val("rd_en_strobe", rd_en, !is_wr);
        if (is_wr) begin
            check_val("wr_addr", wr_addr, m_addr[w]);
            check_val("wr_data", wr_data, m_wdata[w]);
        end else begin
            check_val("rd_addr", rd_addr, m_addr[w]);
        end
        check_val("done_at_grant", cdone, 0);
        if (drop_early) begin
            if (is_wr) wr_req[w] = 1'b0;
            else       rd_req[w] = 1'b0;
        end

        if (no_fin) begin
            n = 0;
            while (cdone == 2'b00 && n < TO + 8) begin
                tick();
                n++;
            end
            check_val("timeout_lat_lo", n >= TO, 1);
            check_val("timeout_lat_hi", n <= TO + 1, 1);
            m_tout = 1'b1;
        end else begin
            for (int i = 0; i < delay; i++) begin
                if (inject && i == 0) begin
                    if (is_wr) rd_fin = 1'b1;
                    else       wr_fin = 1'b1;
                end
                tick();
                rd_fin = 1'b0;
                wr_fin = 1'b0;
                check_val("en_one_cycle", {rd_en, wr_en}, 0);
                check_val("wait_busy", busy, 1);
                check_val("wait_no_done", cdone, 0);
            end
            mem_rdata = rdv;
            if (is_wr) wr_fin = 1'b1;
            else       rd_fin = 1'b1;
            tick();
            rd_fin    = 1'b0;
            wr_fin    = 1'b0;
            mem_rdata = rand_data();
            if (!is_wr) m_rdata[w] = rdv;
        end

        check_val("done_pulse", cdone, (w == 1) ? 2'b10 : 2'b01);
        check_val("rdata0", rdat_o[0], m_rdata[0]);
        check_val("rdata1", rdat_o[1], m_rdata[1]);
        check_val("tout_flag", timeout_err, m_tout);
        check_val("done_busy", busy, 1);
        if (is_wr) pend_wr[w] = 1'b0;
        else       pend_rd[w] = 1'b0;
        drive_reqs();
        tick();
        check_val("done_cleared", cdone, 0);
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        rd_req = '0; wr_req = '0;
        m_addr[0] = '0; m_addr[1] = '0;
        m_wdata[0] = '0; m_wdata[1] = '0;
        do_reset();

        // Lone read from requester 0
        pend_rd[0] = 1'b1;
        m_addr[0]  = 27'h0000100;
        run_round(4, 0, 0, 0, {16{8'hA5}});
        check_val("lone_rd_c1_untouched", rdat_o[1], 0);

        // Contention twice after reset: c0, c1, then c0 again
        do_reset();
        pend_wr = 2'b11;
        m_addr[0] = 27'h10; m_wdata[0] = rand_data();
        m_addr[1] = 27'h20; m_wdata[1] = rand_data();
        run_round(2, 0, 0, 0, rand_data());
        check_val("cont_first_c0", grant, 0);
        run_round(1, 0, 0, 0, rand_data());
        pend_wr = 2'b11;
        drive_reqs();
        run_round(3, 0, 0, 0, rand_data());
        check_val("cont_again_c0", grant, 0);
        run_round(0, 0, 0, 0, rand_data());

        // Write before read on requester 1
        pend_rd[1] = 1'b1; pend_wr[1] = 1'b1;
        m_addr[1] = 27'h5A5A5A5; m_wdata[1] = rand_data();
        run_round(2, 0, 0, 0, rand_data());
        run_round(2, 0, 0, 0, rand_data());
        check_val("wbr_pending_cleared", {pend_rd[1], pend_wr[1]}, 0);

        // Randomized traffic
        for (int r = 0; r < 80; r++) begin
            gen_reqs();
            run_round($urandom_range(6), 0, ($urandom_range(3) == 0),
                      ($urandom_range(7) == 0), rand_data());
        end
        while (pend_rd != 2'b00 || pend_wr != 2'b00)
            run_round($urandom_range(3), 0, 0, 0, rand_data());

        // Timeout, then normal service with sticky flag
        pend_rd[0] = 1'b1;
        m_addr[0]  = 27'h0ABCDEF;
        run_round(0, 1, 0, 0, rand_data());
        pend_wr[1] = 1'b1;
        m_addr[1]  = 27'h0000333; m_wdata[1] = rand_data();
        run_round(2, 0, 0, 0, rand_data());
        check_val("tout_sticky", timeout_err, 1);

        // Reset during WR_WAIT abandons the transaction
        pend_wr[0] = 1'b1;
        m_addr[0]  = 27'h0000777; m_wdata[0] = rand_data();
        drive_reqs();
        tick();
        check_val("mid_wr_en", wr_en, 1);
        tick();
        #2;
        ARESET = 1'b1;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge ACLK);
        ARESET = 1'b0;
        wr_fin = 1'b1;
        tick();
        wr_fin = 1'b0;
        check_val("late_fin_no_done", cdone, 0);
        check_val("late_fin_idle", busy, 0);
        repeat (3) tick();
        check_val("late_fin_still_no_done", cdone, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
